// File: rtl/cam_cfg_pkg.sv
// Shared state encodings and table/bus constants for the OV7670 configuration sequencer.
// Build option: define CAM_CFG_NACK_CHK_EN to treat a high 9th bit as NACK and abort.
package cam_cfg_pkg;

    typedef logic [2:0] cam_cfg_state_t;
    localparam cam_cfg_state_t S_IDLE   = 3'd0,
                               S_FETCH  = 3'd1,
                               S_DECODE = 3'd2,
                               S_WRITE  = 3'd3,
                               S_DELAY  = 3'd4,
                               S_NEXT   = 3'd5,
                               S_FIN    = 3'd6,
                               S_ERROR  = 3'd7;

    typedef logic [2:0] sccb_state_t;
    localparam sccb_state_t W_IDLE  = 3'd0,
                            W_START = 3'd1,
                            W_BYTE  = 3'd2,
                            W_STOP  = 3'd3,
                            W_GAP   = 3'd4;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;

    localparam int BITS_PER_BYTE = 9;
    localparam int BYTES_PER_WR  = 3;
    localparam int START_QTRS    = 2;
    localparam int BIT_QTRS      = 4;
    localparam int STOP_QTRS     = 3;
    localparam int GAP_QTRS      = 4;

`ifdef CAM_CFG_NACK_CHK_EN
    localparam bit NACK_CHK = 1'b1;
`else
    localparam bit NACK_CHK = 1'b0;
`endif

endpackage

// File: rtl/cam_cfg_seq_sccb_wr.sv
// One SCCB 3-phase write (START, ID/reg/val bytes, STOP, idle gap) on a quarter-period tick.
// Aborts to STOP after a NACKed byte only when CAM_CFG_NACK_CHK_EN is defined.
module sccb_wr
    import cam_cfg_pkg::*;
#(
    parameter int QTR = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] id,
    input  logic [7:0] reg_addr,
    input  logic [7:0] val,
    input  logic       sda_i,
    output logic       ready,
    output logic       nack,
    output logic       scl,
    output logic       sda_oe
);
    localparam int TW = $clog2(QTR + 1);

    sccb_state_t   st, st_n;
    logic [1:0]    q, q_n;
    logic [3:0]    bitn, bitn_n;
    logic [1:0]    byten, byten_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          nack_n, scl_n, sda_oe_n, tick;
    logic [23:0]   data;
    logic [7:0]    cur_byte;

    assign ready = (st == W_IDLE);
    assign tick  = (tcnt == TW'(QTR - 1));

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        st_n    = st;
        q_n     = q;
        bitn_n  = bitn;
        byten_n = byten;
        nack_n  = nack;
        tcnt_n  = (st == W_IDLE || tick) ? '0 : tcnt + 1'b1;
        case (st)
            W_IDLE: if (go) begin
                st_n   = W_START;
                q_n    = '0;
                nack_n = 1'b0;
            end
            W_START: if (tick) begin
                if (q == 2'(START_QTRS - 1)) begin
                    st_n    = W_BYTE;
                    q_n     = '0;
                    bitn_n  = '0;
                    byten_n = '0;
                end else q_n = q + 1'b1;
            end
            W_BYTE: if (tick) begin
                // ACK slot is sampled at the end of the first SCL-high quarter
                if (q == 2'd2 && bitn == 4'(BITS_PER_BYTE - 1) && sda_i) nack_n = 1'b1;
                if (q == 2'(BIT_QTRS - 1)) begin
                    q_n = '0;
                    if (bitn == 4'(BITS_PER_BYTE - 1)) begin
                        bitn_n = '0;
                        if (byten == 2'(BYTES_PER_WR - 1) || (NACK_CHK && nack)) st_n = W_STOP;
                        else byten_n = byten + 1'b1;
                    end else bitn_n = bitn + 1'b1;
                end else q_n = q + 1'b1;
            end
            W_STOP: if (tick) begin
                if (q == 2'(STOP_QTRS - 1)) begin
                    st_n = W_GAP;
                    q_n  = '0;
                end else q_n = q + 1'b1;
            end
            W_GAP: if (tick) begin
                if (q == 2'(GAP_QTRS - 1)) begin
                    st_n = W_IDLE;
                    q_n  = '0;
                end else q_n = q + 1'b1;
            end
            default: st_n = W_IDLE;
        endcase
    end

    // Bus levels are decoded from the next state so scl/sda_oe leave a flop, glitch-free.
    always_comb begin
        case (byten_n)
            2'd0:    cur_byte = data[23:16];
            2'd1:    cur_byte = data[15:8];
            default: cur_byte = data[7:0];
        endcase
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
        case (st_n)
            W_START: sda_oe_n = (q_n == 2'd1);
            W_BYTE: begin
                scl_n    = q_n[1];
                sda_oe_n = (bitn_n != 4'(BITS_PER_BYTE - 1)) && !cur_byte[~bitn_n[2:0]];
            end
            W_STOP: begin
                scl_n    = (q_n != 2'd0);
                sda_oe_n = (q_n != 2'd2);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= W_IDLE;
            q      <= '0;
            bitn   <= '0;
            byten  <= '0;
            tcnt   <= '0;
            nack   <= 1'b0;
            scl    <= 1'b1;
            sda_oe <= 1'b0;
        end else begin
            st     <= st_n;
            q      <= q_n;
            bitn   <= bitn_n;
            byten  <= byten_n;
            tcnt   <= tcnt_n;
            nack   <= nack_n;
            scl    <= scl_n;
            sda_oe <= sda_oe_n;
        end
    end

    // NOTE: the payload register needs no reset; it is always loaded on go before it is shifted out.
    always_ff @(posedge clk) begin
        if (go && ready) data <= {id, reg_addr, val};
    end

endmodule

// File: rtl/cam_cfg_seq.sv
// OV7670 boot configuration: walks a {reg,val} ROM table and issues one SCCB write per entry.
// Build option: CAM_CFG_NACK_CHK_EN (via cam_cfg_pkg) enables abort-on-NACK and the err flag.
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int          CLK_HZ   = 100_000_000,
    parameter int          SCCB_HZ  = 100_000,
    parameter int          NUM_REGS = 128,
    parameter logic [7:0]  DEV_ID   = 8'h42,
    parameter int          DELAY_MS = 10,
    localparam int         AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          scl,
    output logic          sda_oe,
    input  logic          sda_i,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] cfg_index
);
    localparam int     QTR   = CLK_HZ / (4 * SCCB_HZ);
    localparam longint DLY_L = longint'(DELAY_MS) * longint'(CLK_HZ) / 1000;
    localparam int     DLY   = int'(DLY_L);
    localparam int     DW    = $clog2(DLY + 2);

    cam_cfg_state_t st;
    logic [15:0]    entry;
    logic [DW-1:0]  dcnt;
    logic           go, wr_ready, wr_nack;

    assign go = (st == S_DECODE) && (entry != END_MARK) && (entry != DELAY_MARK);

    sccb_wr #(.QTR(QTR)) u_wr (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .id       (DEV_ID),
        .reg_addr (entry[15:8]),
        .val      (entry[7:0]),
        .sda_i    (sda_i),
        .ready    (wr_ready),
        .nack     (wr_nack),
        .scl      (scl),
        .sda_oe   (sda_oe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            rom_addr  <= '0;
            cfg_index <= '0;
            entry     <= '0;
            dcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (st)
                S_IDLE: if (start) begin
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    rom_addr <= '0;
                    st       <= S_FETCH;
                end
                S_FETCH: begin
                    entry     <= rom_data;
                    cfg_index <= rom_addr;
                    st        <= S_DECODE;
                end
                S_DECODE: begin
                    if (entry == END_MARK) st <= S_FIN;
                    else if (entry == DELAY_MARK) begin
                        dcnt <= '0;
                        st   <= S_DELAY;
                    end else st <= S_WRITE;
                end
                S_WRITE: if (wr_ready) st <= (NACK_CHK && wr_nack) ? S_ERROR : S_NEXT;
                S_DELAY: begin
                    if (dcnt == DW'(DLY - 1)) st <= S_NEXT;
                    else dcnt <= dcnt + 1'b1;
                end
                // The table never wraps: the last slot ends the sequence even without END_MARK
                S_NEXT: begin
                    if (rom_addr == AW'(NUM_REGS - 1)) st <= S_FIN;
                    else begin
                        rom_addr <= rom_addr + 1'b1;
                        st       <= S_FETCH;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                S_ERROR: begin
                    err  <= 1'b1;
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cam_cfg_seq.md
Name: cam_cfg_seq

Overview:
- Boot-time configuration sequencer for the OV7670 camera.
- Walks a register table held in an external `rom` instance (`{reg, val}` per 16-bit entry) and issues one SCCB 3-phase write per entry.
- Supports inline delay and end markers in the table.
- Sits between top level and the camera SCCB pins; top level gates frame capture on `done`.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCCB_HZ, 100_000, SCL bit rate; quarter period QTR = CLK_HZ/(4*SCCB_HZ) cycles (250 at defaults).
- NUM_REGS, 128, table depth; `rom_addr` width AW = $clog2(NUM_REGS).
- DEV_ID, 8'h42, SCCB write ID byte.
- DELAY_MS, 10, wait time for a delay-marker entry.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin sequence at entry 0.
- rom_addr  out  AW  table address.
- rom_data  in  16  table entry, combinational from rom_addr: [15:8] reg, [7:0] val.
- scl  out  1  SCCB clock, push-pull.
- sda_oe  out  1  1 = pull SDA low; 0 = release (pull-up).
- sda_i  in  1  SDA pin sample.
- busy  out  1  sequence in progress.
- done  out  1  sticky; table completed.
- err  out  1  sticky; sequence aborted.
- cfg_index  out  AW  entry currently or last processed.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction): scl=1, sda_oe=0, busy=0, done=0, err=0, rom_addr=0, cfg_index=0, state IDLE. The bus is released at once.
- Quarter-tick counter runs only while busy. All bus edges align to tick.
- FSM states:
  - IDLE -> FETCH on start. Clears done/err, sets busy, rom_addr=0.
  - FETCH: one cycle; registers rom_data and sets cfg_index=rom_addr.
  - DECODE:
    - 16'hFFFF (END_MARK) -> FIN.
    - 16'hFFF0 (DELAY_MARK) -> DELAY.
    - Otherwise -> START.
  - START: 2 quarters. Q0: SDA released, SCL high. Q1: SDA low. Then SCL low.
  - BYTE: 3 bytes (DEV_ID, reg, val), MSB first, 9 bits each; the 9th bit releases SDA.
    - Per bit, 4 quarters: Q0 SCL low, SDA set; Q1 SCL low; Q2 SCL high, sample sda_i on 9th bit; Q3 SCL high.
  - STOP: 3 quarters. Q0 SCL low, SDA low; Q1 SCL high; Q2 SDA released.
  - GAP: 4 quarters, bus idle -> NEXT.
  - DELAY: DELAY_MS*CLK_HZ/1000 cycles -> NEXT.
  - NEXT:
    - If rom_addr == NUM_REGS-1 -> FIN (no wrap).
    - Else rom_addr+1 -> FETCH.
  - FIN: done=1, busy=0 -> IDLE.
  - ERROR (feature only): err=1, busy=0 -> IDLE.
- Timing: one write = 2+108+3+4 = 117 quarters; start-to-first-SDA-fall = 2 cycles + 1 quarter.
- Boundary rules:
  - start while busy: ignored.
  - start when done/err set: full restart from entry 0.
  - start coincident with rst: rst wins.
  - DEV_ID is a constant, never taken from the table.
  - rom_data is read only in FETCH; changes at other times are don't-care.

Optional Feature:
- Macro: CAM_CFG_NACK_CHK_EN.
- Defined: the 9th-bit sample is the ACK. sda_i=1 in any byte marks NACK. The sequencer finishes the current bit, issues STOP, enters ERROR, and leaves rom_addr/cfg_index at the failing entry. done stays 0.
- Undefined: the 9th bit is don't-care per SCCB, sda_i is unused, and err is tied 0.

Decomposition:
- Package cam_cfg_pkg holds:
  - the state enum cam_cfg_state_t;
  - END_MARK = 16'hFFFF and DELAY_MARK = 16'hFFF0;
  - phase/bit-count constants (BITS_PER_BYTE=9, BYTES_PER_WR=3).
- Sub-module sccb_wr handles the tick generator plus START/BYTE/STOP/GAP for one write.
  - Handshake: go pulse accepted only when ready=1; inputs id, reg, val.
  - Outputs: ready, nack.
- cam_cfg_seq keeps table walking, decode, delay and status.

Test Plan:
- Table {12'80-style 16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF}, one start pulse -> bus monitor decodes writes (42,12,80) then (42,11,00), separated by >= DELAY_MS; done=1, busy=0, cfg_index=3.
- Quarter timing at CLK_HZ=100M, SCCB_HZ=100k -> SCL period 1000 cycles, high 500; SDA changes only while SCL low except START/STOP edges.
- Table with no END_MARK, NUM_REGS=4 -> exactly 4 writes, rom_addr stops at 3, done=1.
- rst asserted mid-byte -> scl=1, sda_oe=0 in the same cycle (asynchronous); a later start replays from entry 0.
- start pulsed while busy -> no effect on write count. start after done -> done clears next cycle and the sequence replays.
- With CAM_CFG_NACK_CHK_EN, slave model NACKs the reg byte of entry 2 -> STOP issued, err=1, done=0, cfg_index=2. Without the macro, the same stimulus completes with done=1.
